up_seq: RTL and testbench
=========================

Name: up_seq

Overview:
- Micro-sequencer that drives the 4-entry, 8-bit register file ("up") from the initiator side.
- Accepts one 16-bit instruction per valid/ready handshake.
- Drives the register-file read selects and captures both operands.
- Executes a small ALU operation, then drives the write select, write data and write enable to write back.
- Sits between an instruction source (stimulus bench or future fetch unit) and the register file.

Parameters:
- DATA_W, 8, datapath width; must equal the register-file width.
- INSTR_W, 16, instruction width; fixed field layout below.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  16  [15:12] opcode, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm.
- rf_sel_a  out  2  register-file read select A.
- rf_sel_b  out  2  register-file read select B.
- rf_data_a  in  8  register-file read data A; combinational from rf_sel_a.
- rf_data_b  in  8  register-file read data B; combinational from rf_sel_b.
- rf_sel_write  out  3  write select; bit2=1 writes all four registers, else [1:0] selects one.
- rf_we  out  1  write enable; the register file writes only when high.
- rf_data_in  out  8  write data.
- done  out  1  one-cycle pulse when an instruction retires.
- result  out  8  last computed value; held until the next retire.
- flag_z  out  1  result == 0; updated on retire.
- flag_c  out  1  carry/borrow/shifted-out bit; updated on retire.
- err  out  1  high for the done cycle of an illegal opcode.

Behaviour:
- Reset: synchronous. When rst is high at a rising edge, state<=IDLE and every output and internal register goes to 0, except instr_ready=1. Reset mid-instruction aborts it: no write and no done.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to READ.
- READ: rf_sel_a=ra, rf_sel_b=rb. At the edge leaving READ, capture rf_data_a/rf_data_b into op_a/op_b. Go to EXEC.
- EXEC: compute into res_q and c_q. Go to WB.
- WB: rf_data_in=res_q. done=1. result, flag_z and flag_c update at this edge. Go to IDLE.
  - Legal write ops: rf_we=1 and rf_sel_write={0,rd}; BCAST uses 3'b100.
  - NOP and CMP: rf_we=0 and rf_sel_write=0.
  - Illegal opcodes (0xC..0xF): rf_we=0, err=1, result and flags unchanged.
- Latency and throughput: handshake in cycle 0, done in cycle 3, instr_ready back high in cycle 4. One instruction per 4 cycles; no pipelining.
- instr_ready is low in READ/EXEC/WB. instr_valid in those states is ignored and not queued.
- rf_we is high only in WB. rf_sel_a/rf_sel_b/rf_sel_write/rf_data_in are 0 whenever not in use.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd<=imm
  - 2 MOV: rd<=A
  - 3 ADD: {c,rd}<=A+B
  - 4 SUB: rd<=A-B, c=borrow
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 NOT: rd<=~A
  - 9 SHL: rd<=A<<1, c=A[7]
  - A SHR: rd<=A>>1, c=A[0]
  - B BCAST: all regs<=imm
- CMP is not a separate opcode; reserved.
- Arithmetic is DATA_W+1 bits internally; results are truncated to DATA_W with wrap-around. flag_c=0 for ops without carry semantics.
- For LDI/BCAST, bits [7:6] still drive rf_sel_b; the value read is ignored.
- rd==ra or rd==rb is legal: operands are captured in READ, before the WB write.

Decomposition:
- Package up_pkg holds:
  - opcode localparams (OP_NOP..OP_BCAST);
  - field position constants;
  - state encoding constants;
  - WR_ALL = 3'b100.
- One sub-module up_alu, purely combinational: (opcode, op_a, op_b, imm) -> (res, carry, illegal). The FSM lives in up_seq.

Test Plan:
- Reset then LDI r1,0x3C -> done in cycle 3; rf_we=1, rf_sel_write=3'b001, rf_data_in=0x3C; flag_z=0.
- BCAST 0xAA then MOV r2,r0 -> first WB: rf_sel_write=3'b100, data 0xAA; second WB: rf_sel_a=0 in READ, writes 0xAA to r2.
- Regfile r0=0xF0, r1=0x20; ADD r3,r0,r1 -> rf_data_in=0x10, flag_c=1, flag_z=0; SUB r3,r1,r1 -> 0x00, flag_z=1, flag_c=0.
- SHL with A=0x81 -> 0x02, c=1. SHR with A=0x81 -> 0x40, c=1.
- Opcode 0xE -> done=1, err=1, rf_we=0, result and flags unchanged. Holding instr_valid high throughout -> accepted exactly once per 4 cycles.
- Assert rst during EXEC of ADD -> no rf_we pulse, no done, outputs 0, instr_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/up_pkg.sv
// up_pkg: shared constants and types for the up register-file micro-sequencer.
//   - opcode encodings (OP_NOP..OP_BCAST); 0xC..0xF are reserved/illegal
//   - instruction field positions and a decode helper
//   - sequencer state encoding
//   - WR_ALL: write select that hits all four registers at once
package up_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_MOV   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_BCAST = 4'hB;

  // rb and imm overlap on purpose: [7:6] is both rb and the top of imm.
  localparam int OPC_HI = 15, OPC_LO = 12;
  localparam int RD_HI  = 11, RD_LO  = 10;
  localparam int RA_HI  = 9,  RA_LO  = 8;
  localparam int RB_HI  = 7,  RB_LO  = 6;
  localparam int IMM_HI = 7,  IMM_LO = 0;

  localparam logic [2:0] WR_ALL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] w);
    instr_t d;
    d.opc = w[OPC_HI:OPC_LO];
    d.rd  = w[RD_HI:RD_LO];
    d.ra  = w[RA_HI:RA_LO];
    d.rb  = w[RB_HI:RB_LO];
    d.imm = w[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/up_alu.sv
// up_alu: combinational ALU for the up sequencer.
//   opc     in  opcode
//   op_a    in  operand A (captured register read A)
//   op_b    in  operand B (captured register read B)
//   imm     in  8-bit immediate
//   res     out result, truncated to DATA_W
//   carry   out carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
//   illegal out opcode is reserved (0xC..0xF); res/carry are 0 then
module up_alu
  import up_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opc,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              illegal
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide    = '0;
    res     = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    unique case (opc)
      OP_NOP:   ;
      OP_LDI:   res = DATA_W'(imm);
      OP_MOV:   res = op_a;
      OP_ADD: begin
        wide  = {1'b0, op_a} + {1'b0, op_b};
        res   = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow.
        wide  = {1'b0, op_a} - {1'b0, op_b};
        res   = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      OP_AND:   res = op_a & op_b;
      OP_OR:    res = op_a | op_b;
      OP_XOR:   res = op_a ^ op_b;
      OP_NOT:   res = ~op_a;
      OP_SHL: begin
        res   = {op_a[DATA_W-2:0], 1'b0};
        carry = op_a[DATA_W-1];
      end
      OP_SHR: begin
        res   = {1'b0, op_a[DATA_W-1:1]};
        carry = op_a[0];
      end
      OP_BCAST: res = DATA_W'(imm);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/up_seq.sv
// up_seq: micro-sequencer driving the 4x8 "up" register file.
// One instruction per valid/ready handshake, four cycles each:
// IDLE (accept) -> READ (drive selects, capture operands) -> EXEC -> WB.
//   clk, rst        clock / synchronous active-high reset
//   instr_valid/ready, instr   instruction handshake
//   rf_sel_a/b, rf_data_a/b    register-file read ports (data is combinational)
//   rf_sel_write, rf_we, rf_data_in   register-file write port
//   done            one-cycle retire pulse (WB)
//   result, flag_z, flag_c     last retired value and flags
//   err             high in WB of an illegal opcode
module up_seq
  import up_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [1:0]         rf_sel_a,
  output logic [1:0]         rf_sel_b,
  input  logic [DATA_W-1:0]  rf_data_a,
  input  logic [DATA_W-1:0]  rf_data_b,
  output logic [2:0]         rf_sel_write,
  output logic               rf_we,
  output logic [DATA_W-1:0]  rf_data_in,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               err
);

  state_t              state, state_nx;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   op_a, op_b, res_q, alu_res;
  logic                c_q, ill_q, alu_c, alu_ill;
  instr_t              dec;

  assign dec = decode(instr_q);

  up_alu #(.DATA_W(DATA_W)) u_alu (
    .opc     (dec.opc),
    .op_a    (op_a),
    .op_b    (op_b),
    .imm     (dec.imm),
    .res     (alu_res),
    .carry   (alu_c),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (instr_valid) instr_q <= instr;
        S_READ: begin
          op_a <= rf_data_a;
          op_b <= rf_data_b;
        end
        S_EXEC: begin
          res_q <= alu_res;
          c_q   <= alu_c;
          ill_q <= alu_ill;
        end
        S_WB: if (!ill_q) begin
          result <= res_q;
          flag_z <= (res_q == '0);
          flag_c <= c_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    rf_sel_a     = '0;
    rf_sel_b     = '0;
    rf_sel_write = '0;
    rf_we        = 1'b0;
    rf_data_in   = '0;
    done         = 1'b0;
    err          = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = S_READ;
      end
      S_READ: begin
        rf_sel_a = dec.ra;
        rf_sel_b = dec.rb;
        state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        done       = 1'b1;
        err        = ill_q;
        rf_data_in = res_q;
        // NOP retires without touching the register file.
        if (!ill_q && dec.opc != OP_NOP) begin
          rf_we        = 1'b1;
          rf_sel_write = (dec.opc == OP_BCAST) ? WR_ALL : {1'b0, dec.rd};
        end
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_up_seq.sv
module tb_up_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [15:0] instr;
  logic [1:0] rf_sel_a, rf_sel_b;
  logic [7:0] rf_data_a, rf_data_b;
  logic [2:0] rf_sel_write;
  logic       rf_we;
  logic [7:0] rf_data_in;
  logic       done;
  logic [7:0] result;
  logic       flag_z, flag_c, err;

  int n_chk  = 0;
  int n_fail = 0;

  // captured per-phase observations of the last instruction
  logic [1:0] rd_sa, rd_sb;
  logic       rd_ready, rd_done, ex_ready, ex_done, ex_we;
  logic       wb_done, wb_we, wb_err, wb_ready;
  logic [2:0] wb_sel;
  logic [7:0] wb_data;

  always #5 clk = ~clk;

  // register-file model the sequencer talks to
  logic [7:0] rf [4] = '{default: 8'h00};
  assign rf_data_a = rf[rf_sel_a];
  assign rf_data_b = rf[rf_sel_b];
  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_sel_write[2]) for (int k = 0; k < 4; k++) rf[k] <= rf_data_in;
      else rf[rf_sel_write[1:0]] <= rf_data_in;
    end
  end

  up_seq #(.DATA_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rf_sel_write(rf_sel_write), .rf_we(rf_we), .rf_data_in(rf_data_in),
    .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c), .err(err)
  );

  // Issue one instruction from an IDLE negedge; returns at the IDLE negedge
  // after WB with each phase's outputs captured.
  task automatic run(input logic [15:0] ins);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0;
    rd_sa = rf_sel_a; rd_sb = rf_sel_b; rd_ready = instr_ready; rd_done = done;
    @(negedge clk);
    ex_ready = instr_ready; ex_done = done; ex_we = rf_we;
    @(negedge clk);
    wb_done = done; wb_we = rf_we; wb_err = err; wb_sel = rf_sel_write;
    wb_data = rf_data_in; wb_ready = instr_ready;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
    repeat (2) @(negedge clk);
    n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", instr_ready); end
    n_chk++; if ({done, rf_we, err} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b exp 000", {done, rf_we, err}); end
    n_chk++; if ({result, flag_z, flag_c} !== 10'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 000", {result, flag_z, flag_c}); end
    n_chk++; if ({rf_sel_a, rf_sel_b, rf_sel_write, rf_data_in} !== 15'h0) begin n_fail++; $display("FAIL reset_sel: got %h exp 0", {rf_sel_a, rf_sel_b, rf_sel_write, rf_data_in}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi;
    run(16'h143C);  // LDI r1,0x3C
    n_chk++; if ({rd_ready, rd_done, ex_ready, ex_done, ex_we} !== 5'b0) begin n_fail++; $display("FAIL ldi_latency: got %b exp 00000", {rd_ready, rd_done, ex_ready, ex_done, ex_we}); end
    n_chk++; if ({wb_done, wb_we, wb_err, wb_ready} !== 4'b1100) begin n_fail++; $display("FAIL ldi_wb_ctl: got %b exp 1100", {wb_done, wb_we, wb_err, wb_ready}); end
    n_chk++; if (wb_sel !== 3'b001) begin n_fail++; $display("FAIL ldi_sel: got %b exp 001", wb_sel); end
    n_chk++; if (wb_data !== 8'h3C) begin n_fail++; $display("FAIL ldi_data: got %h exp 3c", wb_data); end
    n_chk++; if ({result, flag_z, flag_c} !== {8'h3C, 2'b00}) begin n_fail++; $display("FAIL ldi_result: got %h %b%b exp 3c 00", result, flag_z, flag_c); end
    n_chk++; if ({instr_ready, done, rf_we} !== 3'b100) begin n_fail++; $display("FAIL ldi_idle: got %b exp 100", {instr_ready, done, rf_we}); end
  endtask

  task automatic test_bcast_mov;
    run(16'hB0AA);  // BCAST 0xAA; imm[7:6]=2 still drives rf_sel_b
    n_chk++; if (rd_sb !== 2'd2) begin n_fail++; $display("FAIL bcast_selb: got %0d exp 2", rd_sb); end
    n_chk++; if ({wb_we, wb_sel, wb_data} !== {1'b1, 3'b100, 8'hAA}) begin n_fail++; $display("FAIL bcast_wb: got %b %b %h exp 1 100 aa", wb_we, wb_sel, wb_data); end
    run(16'h2800);  // MOV r2,r0
    n_chk++; if (rd_sa !== 2'd0) begin n_fail++; $display("FAIL mov_sela: got %0d exp 0", rd_sa); end
    n_chk++; if ({wb_we, wb_sel, wb_data} !== {1'b1, 3'b010, 8'hAA}) begin n_fail++; $display("FAIL mov_wb: got %b %b %h exp 1 010 aa", wb_we, wb_sel, wb_data); end
  endtask

  task automatic test_add_sub;
    run(16'h10F0);  // LDI r0,0xF0
    run(16'h1420);  // LDI r1,0x20
    run(16'h3C40);  // ADD r3,r0,r1 -> 0x110
    n_chk++; if ({rd_sa, rd_sb} !== 4'b0001) begin n_fail++; $display("FAIL add_sel: got %b exp 0001", {rd_sa, rd_sb}); end
    n_chk++; if ({wb_sel, wb_data} !== {3'b011, 8'h10}) begin n_fail++; $display("FAIL add_wb: got %b %h exp 011 10", wb_sel, wb_data); end
    n_chk++; if ({result, flag_z, flag_c} !== {8'h10, 2'b01}) begin n_fail++; $display("FAIL add_flags: got %h %b%b exp 10 01", result, flag_z, flag_c); end
    run(16'h4D40);  // SUB r3,r1,r1 -> 0
    n_chk++; if (wb_data !== 8'h00) begin n_fail++; $display("FAIL sub0_data: got %h exp 00", wb_data); end
    n_chk++; if ({result, flag_z, flag_c} !== {8'h00, 2'b10}) begin n_fail++; $display("FAIL sub0_flags: got %h %b%b exp 00 10", result, flag_z, flag_c); end
    run(16'h4D00);  // SUB r3,r1,r0: 0x20-0xF0 -> 0x30, borrow
    n_chk++; if ({result, flag_z, flag_c} !== {8'h30, 2'b01}) begin n_fail++; $display("FAIL sub_borrow: got %h %b%b exp 30 01", result, flag_z, flag_c); end
  endtask

  task automatic test_shift_logic;
    run(16'h1881);  // LDI r2,0x81
    run(16'h9E00);  // SHL r3,r2
    n_chk++; if ({wb_data, flag_c, flag_z} !== {8'h02, 2'b10}) begin n_fail++; $display("FAIL shl: got %h %b%b exp 02 10", wb_data, flag_c, flag_z); end
    run(16'hAE00);  // SHR r3,r2
    n_chk++; if ({wb_data, flag_c, flag_z} !== {8'h40, 2'b10}) begin n_fail++; $display("FAIL shr: got %h %b%b exp 40 10", wb_data, flag_c, flag_z); end
    run(16'h7E80);  // XOR r3,r2,r2 -> 0, clears carry
    n_chk++; if ({result, flag_c, flag_z} !== {8'h00, 2'b01}) begin n_fail++; $display("FAIL xor: got %h %b%b exp 00 01", result, flag_c, flag_z); end
    run(16'h8E00);  // NOT r3,r2 -> 0x7E
    n_chk++; if ({wb_data, flag_c, flag_z} !== {8'h7E, 2'b00}) begin n_fail++; $display("FAIL not: got %h %b%b exp 7e 00", wb_data, flag_c, flag_z); end
  endtask

  task automatic test_illegal;
    run(16'h9E00);  // SHL r3,r2 -> result 0x02, c=1
    run(16'hE000);  // reserved opcode
    n_chk++; if ({wb_done, wb_err, wb_we} !== 3'b110) begin n_fail++; $display("FAIL ill_ctl: got %b exp 110", {wb_done, wb_err, wb_we}); end
    n_chk++; if ({result, flag_z, flag_c} !== {8'h02, 2'b01}) begin n_fail++; $display("FAIL ill_hold: got %h %b%b exp 02 01", result, flag_z, flag_c); end
    n_chk++; if ({err, done} !== 2'b00) begin n_fail++; $display("FAIL ill_after: got %b exp 00", {err, done}); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] rdy_pat, done_pat;
    rdy_pat = '0; done_pat = '0;
    instr_valid = 1'b1;
    instr       = 16'h1011;  // LDI r0,0x11 offered continuously
    for (int i = 0; i < 12; i++) begin
      rdy_pat[i]  = instr_ready;
      done_pat[i] = done;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    instr       = 16'h0;
    n_chk++; if (rdy_pat !== 12'h111) begin n_fail++; $display("FAIL b2b_ready: got %h exp 111", rdy_pat); end
    n_chk++; if (done_pat !== 12'h888) begin n_fail++; $display("FAIL b2b_done: got %h exp 888", done_pat); end
    n_chk++; if ({instr_ready, result} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL b2b_end: got %b %h exp 1 11", instr_ready, result); end
  endtask

  task automatic test_reset_mid;
    logic saw;
    saw = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'h3C40;  // ADD r3,r0,r1
    @(negedge clk);          // READ
    instr_valid = 1'b0;
    saw = saw | rf_we | done;
    @(negedge clk);          // EXEC
    saw = saw | rf_we | done;
    rst = 1'b1;
    @(negedge clk);
    saw = saw | rf_we | done;
    n_chk++; if ({result, flag_z, flag_c, rf_data_in, rf_sel_write} !== 21'h0) begin n_fail++; $display("FAIL midrst_outs: got %h %b%b %h %b exp all 0", result, flag_z, flag_c, rf_data_in, rf_sel_write); end
    rst = 1'b0;
    @(negedge clk);
    saw = saw | rf_we | done;
    n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b exp 1", instr_ready); end
    repeat (3) begin @(negedge clk); saw = saw | rf_we | done; end
    n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midrst_nowrite: got %b exp 0", saw); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
    @(negedge clk);
    test_reset;
    test_ldi;
    test_bcast_mov;
    test_add_sub;
    test_shift_logic;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
